// File: rtl/mem_access_ctrl.sv
// Load/store access controller between the MEM stage and a word-wide RAM.
// Handles lane selection, store replication, load extension and ack timeout.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        align_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    typedef enum logic [1:0] {F_OK, F_ALIGN, F_BUS} flag_t;

    state_t      state_q, state_d;
    flag_t       flag_q, flag_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;

    logic        misalign;
    logic        cnt_last;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    assign misalign = (size == 2'b11)
                    || (size == 2'b01 && addr[0])
                    || (size == 2'b10 && addr[1:0] != 2'b00);
    assign cnt_last = (cnt_q == 8'(TIMEOUT - 1));

    // Aligned accesses put the selected lane at offset addr[1:0]*8.
    assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        unique case (size_q)
            2'b00:   load_ext = {{24{sext_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{sext_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            flag_q  <= F_OK;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        flag_d  = flag_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req && misalign) begin
                    state_d = S_RESP;
                    flag_d  = F_ALIGN;
                    rdata_d = '0;
                end else if (req) begin
                    state_d = S_ACCESS;
                    we_d    = we;
                    size_d  = size;
                    sext_d  = sign_ext;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = '0;
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_d = S_RESP;
                    flag_d  = F_OK;
                    rdata_d = we_q ? 32'h0 : load_ext;
                end else if (cnt_last) begin
                    state_d = S_RESP;
                    flag_d  = F_BUS;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = '0;
        done      = 1'b0;
        align_err = 1'b0;
        bus_err   = 1'b0;
        if (state_q == S_ACCESS) begin
            mem_req  = 1'b1;
            mem_we   = we_q;
            mem_addr = {addr_q[31:2], 2'b00};
            unique case (size_q)
                2'b00: begin
                    mem_be    = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = wdata_q;
                end
            endcase
        end
        if (state_q == S_RESP) begin
            done      = (flag_q == F_OK);
            align_err = (flag_q == F_ALIGN);
            bus_err   = (flag_q == F_BUS);
        end
    end

    assign stall = req && (state_q != S_RESP);
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized checks of mem_access_ctrl against a behavioural
// model of lane selection, extension, replication and timeout timing.
module tb_mem_access_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        done;
    logic        align_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int vectors = 0;
    int errs = 0;
    logic [31:0] hold = '0;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .stall(stall),
        .rdata(rdata), .done(done), .align_err(align_err),
        .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] sz,
            input logic sx, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * a[1:0]);
        if (sz == 2'b00) begin
            v = v % 256;
            if (sx && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'b01) begin
            v = v % 65536;
            if (sx && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    task automatic txn(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int ack_at);
        logic bad;
        logic acked;
        logic [3:0] e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        bad = (sz == 2'b11) || (sz == 2'b01 && a[0])
            || (sz == 2'b10 && a[1:0] != 2'b00);
        if (sz == 2'b00) begin
            e_be = 4'(1 << a[1:0]);
            e_wd = (wd % 256) * 32'h01010101;
        end else if (sz == 2'b01) begin
            e_be = 4'(3 << (2 * a[1]));
            e_wd = (wd % 65536) * 32'h00010001;
        end else begin
            e_be = 4'hF;
            e_wd = wd;
        end
        req = 1'b1; we = w; size = sz; sign_ext = sx;
        addr = a; wdata = wd;
        #1;
        chk("stall_idle", 32'(stall), 32'd1);
        acked = 1'b0;
        if (bad) begin
            @(posedge clk); #1;
            chk("align_err", 32'(align_err), 32'd1);
            chk("align_done", 32'(done), 32'd0);
            chk("align_bus", 32'(bus_err), 32'd0);
            chk("align_memreq", 32'(mem_req), 32'd0);
            chk("align_stall", 32'(stall), 32'd0);
            chk("align_rdata", rdata, 32'd0);
            hold = '0;
        end else begin
            for (int k = 0; k < TO; k++) begin
                @(posedge clk); #1;
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                chk("acc_memreq", 32'(mem_req), 32'd1);
                chk("acc_memwe", 32'(mem_we), 32'(w));
                chk("acc_addr", mem_addr, a & 32'hFFFFFFFC);
                chk("acc_be", 32'(mem_be), 32'(e_be));
                chk("acc_wdata", mem_wdata, e_wd);
                chk("acc_done", 32'(done), 32'd0);
                chk("acc_stall", 32'(stall), 32'd1);
                if (k == ack_at) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                    acked = 1'b1;
                    break;
                end
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            e_rd = (acked && !w) ? model_load(sz, sx, a, rd) : 32'd0;
            chk("resp_done", 32'(done), 32'(acked));
            chk("resp_bus", 32'(bus_err), 32'(!acked));
            chk("resp_align", 32'(align_err), 32'd0);
            chk("resp_rdata", rdata, e_rd);
            chk("resp_stall", 32'(stall), 32'd0);
            chk("resp_memreq", 32'(mem_req), 32'd0);
            chk("resp_be", 32'(mem_be), 32'd0);
            hold = e_rd;
        end
        req = 1'b0;
        @(posedge clk); #1;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_memreq", 32'(mem_req), 32'd0);
        chk("idle_rdata", rdata, hold);
    endtask

    initial begin
        #2;
        chk("rst_memreq", 32'(mem_req), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_flags", {29'd0, done, align_err, bus_err}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        mem_ack = 1'b1;
        @(posedge clk); #1;
        chk("idle_ack_memreq", 32'(mem_req), 32'd0);
        chk("idle_ack_done", 32'(done), 32'd0);
        mem_ack = 1'b0;

        txn(1'b1, 2'b00, 1'b0, 32'h1003, 32'h000000AB, 32'h0, 0);
        txn(1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 32'h8001FFFF, 2);
        txn(1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 32'h8001FFFF, 2);
        txn(1'b0, 2'b10, 1'b0, 32'h0006, 32'h0, 32'h0, 0);
        txn(1'b0, 2'b00, 1'b1, 32'h0041, 32'h0, 32'h0000F000, -1);
        txn(1'b0, 2'b00, 1'b1, 32'h0041, 32'h0, 32'h0000F000, TO - 1);
        txn(1'b0, 2'b11, 1'b0, 32'h0100, 32'h0, 32'h0, 0);
        txn(1'b1, 2'b01, 1'b0, 32'h0102, 32'h1234BEEF, 32'h0, 1);

        req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h0400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_memreq", 32'(mem_req), 32'd0);
        chk("mid_rst_be", 32'(mem_be), 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        req = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        mem_ack = 1'b0;
        hold = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_memreq", 32'(mem_req), 32'd0);
        end

        for (int n = 0; n < 40; n++) begin
            int at;
            at = int'($urandom_range(0, 17));
            if (at >= TO) at = -1;
            txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom,
                $urandom, $urandom, at);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
